// File: rtl/bram_stream_reader.sv
// Read-side master for a simple dual-port BRAM: fetches LENGTH words from BASE (wrapping)
// and streams them out on valid/ready through a 2-entry buffer that absorbs read latency.
module bram_stream_reader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int LENGTH_WIDTH  = ADDRESS_WIDTH + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDRESS_WIDTH-1:0] base_address_i,
    input  logic [LENGTH_WIDTH-1:0]  length_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ADDRESS_WIDTH-1:0] bram_rd_address_o,
    output logic                     bram_rd_enable_o,
    input  logic [DATA_WIDTH-1:0]    bram_rd_data_i,
    input  logic                     bram_rd_valid_i,
    output logic [DATA_WIDTH-1:0]    m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic                     m_last_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [LENGTH_WIDTH-1:0]  len_q, len_d;
    logic [LENGTH_WIDTH-1:0]  issued_q, issued_d;
    logic                     inflight_q, inflight_d;
    logic                     inflight_last_q, inflight_last_d;
    logic [DATA_WIDTH-1:0]    head_data_q, head_data_d;
    logic                     head_last_q, head_last_d;
    logic [DATA_WIDTH-1:0]    tail_data_q, tail_data_d;
    logic                     tail_last_q, tail_last_d;
    logic [1:0]               count_q, count_d;

    logic                     push;
    logic                     pop;
    logic                     issue;
    logic                     issue_is_last;
    logic [2:0]               pending;

    // A read may only go out if its word is guaranteed a buffer slot once it returns.
    always_comb begin
        pop           = (count_q != 2'd0) && m_ready_i;
        push          = bram_rd_valid_i && inflight_q;
        pending       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue         = (state_q == S_READ) && (pending < 3'd2) && (issued_q < len_q);
        issue_is_last = (issued_q == len_q - LENGTH_WIDTH'(1));
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d   = base_address_i;
                    len_d    = length_i;
                    issued_d = '0;
                    state_d  = (length_i == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                busy_o = 1'b1;
                if (issue) begin
                    addr_d   = addr_q + ADDRESS_WIDTH'(1);
                    issued_d = issued_q + LENGTH_WIDTH'(1);
                    if (issue_is_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                if (pop && head_last_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Set and clear in the same cycle leaves the read marked in flight.
    always_comb begin
        inflight_d      = inflight_q;
        inflight_last_d = inflight_last_q;
        if (issue) begin
            inflight_d      = 1'b1;
            inflight_last_d = issue_is_last;
        end else if (bram_rd_valid_i) begin
            inflight_d = 1'b0;
        end
    end

    always_comb begin
        count_d     = count_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_data_d = bram_rd_data_i;
                    head_last_d = inflight_last_q;
                end else begin
                    tail_data_d = bram_rd_data_i;
                    tail_last_d = inflight_last_q;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_data_d = tail_data_q;
                head_last_d = tail_last_q;
                count_d     = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_data_d = bram_rd_data_i;
                    head_last_d = inflight_last_q;
                end else begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                    tail_data_d = bram_rd_data_i;
                    tail_last_d = inflight_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            head_data_q     <= '0;
            head_last_q     <= 1'b0;
            tail_data_q     <= '0;
            tail_last_q     <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            head_data_q     <= head_data_d;
            head_last_q     <= head_last_d;
            tail_data_q     <= tail_data_d;
            tail_last_q     <= tail_last_d;
            count_q         <= count_d;
        end
    end

    assign bram_rd_enable_o  = issue;
    assign bram_rd_address_o = addr_q;
    assign m_valid_o         = (count_q != 2'd0);
    assign m_data_o          = head_data_q;
    assign m_last_o          = head_last_q;

    // Returned data must always find room; the issue rule makes a full-buffer push impossible.
    assert property (@(posedge clk_i) disable iff (rst_i) !(push && (count_q == 2'd2)));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: a BRAM model feeds the DUT and a scoreboard
// queue holds the expected stream, popped whenever a beat is accepted.
module tb_bram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int LW = 9;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_address_i = '0;
    logic [LW-1:0] length_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] bram_rd_address_o;
    logic          bram_rd_enable_o;
    logic [DW-1:0] bram_rd_data_i = '0;
    logic          bram_rd_valid_i = 1'b0;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i = 1'b1;
    logic          m_last_o;

    logic [DW-1:0] mem [0:255];

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    beats    = 0;
    int    dones    = 0;

    bram_stream_reader #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .LENGTH_WIDTH (LW)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .base_address_i   (base_address_i),
        .length_i         (length_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .bram_rd_address_o(bram_rd_address_o),
        .bram_rd_enable_o (bram_rd_enable_o),
        .bram_rd_data_i   (bram_rd_data_i),
        .bram_rd_valid_i  (bram_rd_valid_i),
        .m_data_o         (m_data_o),
        .m_valid_o        (m_valid_o),
        .m_ready_i        (m_ready_i),
        .m_last_o         (m_last_o)
    );

    always #5 clk_i = ~clk_i;

    // BRAM model with one cycle of read latency; it ignores the DUT reset on purpose.
    always @(posedge clk_i) begin
        bram_rd_valid_i <= bram_rd_enable_o;
        if (bram_rd_enable_o) bram_rd_data_i <= mem[bram_rd_address_o];
    end

    // Scoreboard: every accepted beat is compared against the oldest expectation.
    always @(negedge clk_i) begin : scoreboard
        beat_t e;
        if (!rst_i && m_valid_o && m_ready_i) begin
            beats++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_beat: got data %h last %b, want no beat", m_data_o, m_last_o);
            end else begin
                e = exp_q.pop_front();
                if ({m_data_o, m_last_o} !== e) begin
                    n_fail++;
                    $display("[TB] FAIL stream_beat: got data %h last %b, want data %h last %b",
                             m_data_o, m_last_o, e.data, e.last);
                end
            end
        end
        if (!rst_i && done_o) dones++;
    end

    task automatic step(input logic ready, input logic st);
        @(posedge clk_i);
        #1;
        start_i   = st;
        m_ready_i = ready;
        @(negedge clk_i);
    endtask

    task automatic start_xfer(input logic [AW-1:0] base, input logic [LW-1:0] len);
        beat_t         b;
        logic [AW-1:0] a;
        @(posedge clk_i);
        #1;
        start_i        = 1'b1;
        base_address_i = base;
        length_i       = len;
        for (int i = 0; i < int'(len); i++) begin
            a      = base + AW'(i);
            b.data = mem[a];
            b.last = (i == int'(len) - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b, want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b, want 0", done_o); end
        n_checks++; if (bram_rd_enable_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_en: got %b, want 0", bram_rd_enable_o); end
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b, want 0", m_valid_o); end
        n_checks++; if (m_last_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_last: got %b, want 0", m_last_o); end
        n_checks++; if (bram_rd_address_o !== '0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h, want 00", bram_rd_address_o); end
        n_checks++; if (m_data_o !== '0) begin n_fail++; $display("[TB] FAIL reset_data: got %h, want 00", m_data_o); end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        int   b0, d0;
        logic exp_en, exp_valid;
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = DW'(8'hA0 + i);
        b0 = beats;
        d0 = dones;
        start_xfer(8'h10, 9'd4);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b0);
            exp_en    = (k >= 1 && k <= 4);
            exp_valid = (k >= 3 && k <= 6);
            n_checks++;
            if (bram_rd_enable_o !== exp_en) begin
                n_fail++; $display("[TB] FAIL basic_en c%0d: got %b, want %b", k, bram_rd_enable_o, exp_en);
            end
            if (exp_en) begin
                n_checks++;
                if (bram_rd_address_o !== AW'(8'h10 + k - 1)) begin
                    n_fail++; $display("[TB] FAIL basic_addr c%0d: got %h, want %h", k, bram_rd_address_o, AW'(8'h10 + k - 1));
                end
            end
            n_checks++;
            if (m_valid_o !== exp_valid) begin
                n_fail++; $display("[TB] FAIL basic_valid c%0d: got %b, want %b", k, m_valid_o, exp_valid);
            end
            if (exp_valid) begin
                n_checks++;
                if (m_last_o !== (k == 6)) begin
                    n_fail++; $display("[TB] FAIL basic_last c%0d: got %b, want %b", k, m_last_o, (k == 6));
                end
            end
            n_checks++;
            if (done_o !== (k == 7)) begin
                n_fail++; $display("[TB] FAIL basic_done c%0d: got %b, want %b", k, done_o, (k == 7));
            end
            n_checks++;
            if (busy_o !== (k <= 6)) begin
                n_fail++; $display("[TB] FAIL basic_busy c%0d: got %b, want %b", k, busy_o, (k <= 6));
            end
        end
        #1;
        n_checks++; if (beats - b0 != 4) begin n_fail++; $display("[TB] FAIL basic_beats: got %0d, want 4", beats - b0); end
        n_checks++; if (dones - d0 != 1) begin n_fail++; $display("[TB] FAIL basic_dones: got %0d, want 1", dones - d0); end
    endtask

    task automatic test_backpressure();
        logic [5:0]    pat;
        int            en_cnt, acc_cnt, b0, d0;
        logic          stall, held_l;
        logic [DW-1:0] held_d;
        bit            got_done;
        pat      = 6'b101001;
        b0       = beats;
        d0       = dones;
        en_cnt   = 0;
        acc_cnt  = 0;
        stall    = 1'b0;
        held_d   = '0;
        held_l   = 1'b0;
        got_done = 1'b0;
        start_xfer(8'h10, 9'd4);
        for (int k = 1; k <= 40 && !got_done; k++) begin
            step(pat[(k - 1) % 6], 1'b0);
            if (bram_rd_enable_o) en_cnt++;
            if (m_valid_o && m_ready_i) acc_cnt++;
            n_checks++;
            if (en_cnt - acc_cnt > 2) begin
                n_fail++; $display("[TB] FAIL bp_occupancy c%0d: got %0d outstanding, want at most 2", k, en_cnt - acc_cnt);
            end
            if (stall) begin
                n_checks++;
                if (m_valid_o !== 1'b1 || m_data_o !== held_d || m_last_o !== held_l) begin
                    n_fail++; $display("[TB] FAIL bp_hold c%0d: got valid %b data %h last %b, want valid 1 data %h last %b",
                                       k, m_valid_o, m_data_o, m_last_o, held_d, held_l);
                end
            end
            stall  = m_valid_o && !m_ready_i;
            held_d = m_data_o;
            held_l = m_last_o;
            if (done_o) got_done = 1'b1;
        end
        #1;
        m_ready_i = 1'b1;
        n_checks++; if (!got_done) begin n_fail++; $display("[TB] FAIL bp_timeout: got no done, want done within 40 cycles"); end
        n_checks++; if (beats - b0 != 4) begin n_fail++; $display("[TB] FAIL bp_beats: got %0d, want 4", beats - b0); end
        n_checks++; if (dones - d0 != 1) begin n_fail++; $display("[TB] FAIL bp_dones: got %0d, want 1", dones - d0); end
        n_checks++; if (en_cnt != 4) begin n_fail++; $display("[TB] FAIL bp_reads: got %0d, want 4", en_cnt); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_addr[$];
        logic [AW-1:0] a;
        int            b0;
        bit            got_done;
        mem[8'hFE] = 8'h5A;
        mem[8'hFF] = 8'hC3;
        mem[8'h00] = 8'h3C;
        mem[8'h01] = 8'hE7;
        exp_addr.push_back(8'hFE);
        exp_addr.push_back(8'hFF);
        exp_addr.push_back(8'h00);
        exp_addr.push_back(8'h01);
        b0       = beats;
        got_done = 1'b0;
        start_xfer(8'hFE, 9'd4);
        for (int k = 1; k <= 15 && !got_done; k++) begin
            step(1'b1, 1'b0);
            if (bram_rd_enable_o) begin
                n_checks++;
                if (exp_addr.size() == 0) begin
                    n_fail++; $display("[TB] FAIL wrap_extra_read c%0d: got read of %h, want no read", k, bram_rd_address_o);
                end else begin
                    a = exp_addr.pop_front();
                    if (bram_rd_address_o !== a) begin
                        n_fail++; $display("[TB] FAIL wrap_addr c%0d: got %h, want %h", k, bram_rd_address_o, a);
                    end
                end
            end
            if (done_o) got_done = 1'b1;
        end
        #1;
        n_checks++; if (!got_done) begin n_fail++; $display("[TB] FAIL wrap_timeout: got no done, want done within 15 cycles"); end
        n_checks++; if (exp_addr.size() != 0) begin n_fail++; $display("[TB] FAIL wrap_reads: got %0d reads missing, want 0", exp_addr.size()); end
        n_checks++; if (beats - b0 != 4) begin n_fail++; $display("[TB] FAIL wrap_beats: got %0d, want 4", beats - b0); end
    endtask

    task automatic test_zero_length();
        int d0;
        d0 = dones;
        start_xfer(8'h55, 9'd0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (done_o !== (k == 1)) begin
                n_fail++; $display("[TB] FAIL zero_done c%0d: got %b, want %b", k, done_o, (k == 1));
            end
            n_checks++;
            if (busy_o !== 1'b0 || bram_rd_enable_o !== 1'b0 || m_valid_o !== 1'b0) begin
                n_fail++; $display("[TB] FAIL zero_idle c%0d: got busy %b en %b valid %b, want all 0",
                                   k, busy_o, bram_rd_enable_o, m_valid_o);
            end
        end
        #1;
        n_checks++; if (dones - d0 != 1) begin n_fail++; $display("[TB] FAIL zero_dones: got %0d, want 1", dones - d0); end
    endtask

    task automatic test_start_while_busy();
        int b0, d0;
        for (int i = 0; i < 8; i++) mem[8'h40 + i] = DW'(i * 17 + 3);
        b0 = beats;
        d0 = dones;
        start_xfer(8'h40, 9'd8);
        for (int k = 1; k <= 16; k++) begin
            if (k == 2) begin
                base_address_i = 8'h90;
                length_i       = 9'd5;
            end
            step(1'b1, (k == 2));
            n_checks++;
            if (done_o !== (k == 11)) begin
                n_fail++; $display("[TB] FAIL restart_done c%0d: got %b, want %b", k, done_o, (k == 11));
            end
            n_checks++;
            if (busy_o !== (k <= 10)) begin
                n_fail++; $display("[TB] FAIL restart_busy c%0d: got %b, want %b", k, busy_o, (k <= 10));
            end
        end
        #1;
        n_checks++; if (beats - b0 != 8) begin n_fail++; $display("[TB] FAIL restart_beats: got %0d, want 8", beats - b0); end
        n_checks++; if (dones - d0 != 1) begin n_fail++; $display("[TB] FAIL restart_dones: got %0d, want 1", dones - d0); end
    endtask

    task automatic test_reset_mid_transfer();
        int b0, d0;
        bit got_done;
        for (int i = 0; i < 8; i++) mem[8'h20 + i] = DW'(8'hB0 + i);
        mem[8'h30] = 8'h11;
        mem[8'h31] = 8'h22;
        start_xfer(8'h20, 9'd8);
        for (int k = 1; k <= 3; k++) step(1'b1, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        exp_q.delete();
        d0 = dones;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, done_o, bram_rd_enable_o, m_valid_o, m_last_o} !== 5'b0) begin
            n_fail++; $display("[TB] FAIL midrst_flags: got busy %b done %b en %b valid %b last %b, want all 0",
                               busy_o, done_o, bram_rd_enable_o, m_valid_o, m_last_o);
        end
        n_checks++;
        if (bram_rd_address_o !== '0 || m_data_o !== '0) begin
            n_fail++; $display("[TB] FAIL midrst_buses: got addr %h data %h, want 00 00", bram_rd_address_o, m_data_o);
        end
        for (int k = 6; k <= 9; k++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (m_valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || bram_rd_enable_o !== 1'b0) begin
                n_fail++; $display("[TB] FAIL midrst_quiet c%0d: got valid %b done %b busy %b en %b, want all 0",
                                   k, m_valid_o, done_o, busy_o, bram_rd_enable_o);
            end
        end
        #1;
        n_checks++; if (dones != d0) begin n_fail++; $display("[TB] FAIL midrst_no_done: got %0d dones, want 0", dones - d0); end
        b0       = beats;
        d0       = dones;
        got_done = 1'b0;
        start_xfer(8'h30, 9'd2);
        for (int k = 1; k <= 12 && !got_done; k++) begin
            step(1'b1, 1'b0);
            if (done_o) got_done = 1'b1;
        end
        #1;
        n_checks++; if (!got_done) begin n_fail++; $display("[TB] FAIL midrst_timeout: got no done, want done within 12 cycles"); end
        n_checks++; if (beats - b0 != 2) begin n_fail++; $display("[TB] FAIL midrst_beats: got %0d, want 2", beats - b0); end
        n_checks++; if (dones - d0 != 1) begin n_fail++; $display("[TB] FAIL midrst_dones: got %0d, want 1", dones - d0); end
    endtask

    task automatic test_full_depth();
        int b0, d0, done_cycle, reads;
        b0         = beats;
        d0         = dones;
        done_cycle = -1;
        reads      = 0;
        start_xfer(8'h80, 9'd256);
        for (int k = 1; k <= 300 && done_cycle < 0; k++) begin
            step(1'b1, 1'b0);
            if (bram_rd_enable_o) reads++;
            if (done_o) done_cycle = k;
        end
        #1;
        n_checks++; if (done_cycle != 259) begin n_fail++; $display("[TB] FAIL full_done_cycle: got %0d, want 259", done_cycle); end
        n_checks++; if (reads != 256) begin n_fail++; $display("[TB] FAIL full_reads: got %0d, want 256", reads); end
        n_checks++; if (beats - b0 != 256) begin n_fail++; $display("[TB] FAIL full_beats: got %0d, want 256", beats - b0); end
        n_checks++; if (dones - d0 != 1) begin n_fail++; $display("[TB] FAIL full_dones: got %0d, want 1", dones - d0); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DW'(i) ^ 8'h5A;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid_transfer();
        test_full_depth();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("[TB] FAIL leftover_expect: got %0d beats never seen, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
